memory_access_cycle: RTL and testbench

Memory-access stage of the SimpleRisc five-stage pipeline; consumes the E-M pipeline buffer produced by the execute stage. Issues load/store requests to a data memory over a req/ack handshake and holds the pipeline via a stall while the memory is busy. Aborts requests that are never acknowledged, and registers the M-W buffer for write-back. Also drives the M-stage forwarding value returned to execute.

---
 rtl/memory_access_cycle.sv | 132 +++++++++++++
 tb/tb_memory_access_cycle.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_cycle.sv
// SimpleRisc M stage: data-memory req/ack with stall and timeout abort,
// plus the M-W pipeline buffer and the M-stage forwarding value.
module memory_access_cycle #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_M,
    input  logic [31:0] alu_result_M,
    input  logic [31:0] rd2_M,
    input  logic [31:0] instruction_M,
    input  logic        isLd_M,
    input  logic        isSt_M,
    input  logic        isWb_M,
    input  logic        isCall_M,
    input  logic [3:0]  RD_M,
    input  logic [3:0]  ra_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_M,
    output logic [31:0] data_M_E,
    output logic        mem_err,
    output logic [31:0] pc_W,
    output logic [31:0] alu_result_W,
    output logic [31:0] ld_result_W,
    output logic [31:0] instruction_W,
    output logic        isWb_W,
    output logic        isLd_W,
    output logic        isCall_W,
    output logic [3:0]  RD_W,
    output logic [3:0]  ra_W
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          memop;
    logic          abort;

    assign memop      = isLd_M | isSt_M;
    assign dmem_req   = !rst && memop && (state == IDLE || state == WAIT);
    assign dmem_we    = isSt_M;
    assign dmem_addr  = alu_result_M;
    assign dmem_wdata = rd2_M;
    assign data_M_E   = alu_result_M;

    assign abort   = (state == WAIT) && (cnt == LAST) && !dmem_ack;
    assign stall_M = dmem_req && !dmem_ack && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            mem_err       <= 1'b0;
            pc_W          <= '0;
            alu_result_W  <= '0;
            ld_result_W   <= '0;
            instruction_W <= '0;
            isWb_W        <= 1'b0;
            isLd_W        <= 1'b0;
            isCall_W      <= 1'b0;
            RD_W          <= '0;
            ra_W          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dmem_req && !dmem_ack) begin
                        state <= WAIT;
                        cnt   <= CW'(1);
                    end
                end
                WAIT: begin
                    if (!memop || dmem_ack) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (abort) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            unique case (1'b1)
                stall_M: begin
                    instruction_W <= '0;
                    isWb_W        <= 1'b0;
                    isLd_W        <= 1'b0;
                    isCall_W      <= 1'b0;
                end
                // a faulting access still retires, but writes nothing back
                abort: begin
                    pc_W          <= pc_M;
                    alu_result_W  <= alu_result_M;
                    ld_result_W   <= '0;
                    instruction_W <= instruction_M;
                    isWb_W        <= 1'b0;
                    isLd_W        <= 1'b0;
                    isCall_W      <= 1'b0;
                    RD_W          <= RD_M;
                    ra_W          <= ra_M;
                end
                default: begin
                    pc_W          <= pc_M;
                    alu_result_W  <= alu_result_M;
                    ld_result_W   <= (isLd_M && dmem_ack) ? dmem_rdata : '0;
                    instruction_W <= instruction_M;
                    isWb_W        <= isWb_M;
                    isLd_W        <= isLd_M;
                    isCall_W      <= isCall_M;
                    RD_W          <= RD_M;
                    ra_W          <= ra_M;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_cycle.sv
// Scoreboard bench for memory_access_cycle: stimulus pushes expected
// M-W records, a monitor pops them when the stage stops stalling.
module tb_memory_access_cycle;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_M, alu_result_M, rd2_M, instruction_M;
    logic        isLd_M, isSt_M, isWb_M, isCall_M;
    logic [3:0]  RD_M, ra_M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_M;
    logic [31:0] data_M_E;
    logic        mem_err;
    logic [31:0] pc_W, alu_result_W, ld_result_W, instruction_W;
    logic        isWb_W, isLd_W, isCall_W;
    logic [3:0]  RD_W, ra_W;

    memory_access_cycle #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .pc_M(pc_M), .alu_result_M(alu_result_M), .rd2_M(rd2_M),
        .instruction_M(instruction_M),
        .isLd_M(isLd_M), .isSt_M(isSt_M), .isWb_M(isWb_M),
        .isCall_M(isCall_M), .RD_M(RD_M), .ra_M(ra_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall_M(stall_M), .data_M_E(data_M_E),
        .mem_err(mem_err), .pc_W(pc_W), .alu_result_W(alu_result_W),
        .ld_result_W(ld_result_W), .instruction_W(instruction_W),
        .isWb_W(isWb_W), .isLd_W(isLd_W), .isCall_W(isCall_W),
        .RD_W(RD_W), .ra_W(ra_W)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, alu, ld, ins, addr, wdata;
        logic        wb, isld, call, ab, err, we;
        logic [3:0]  rd, ra;
        int          stalls, reqs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   em_valid = 1'b0;
    bit   err_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic issue(input bit ld, input bit st, input bit wb,
                         input bit call, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rd2,
                         input logic [31:0] ins, input logic [3:0] rd,
                         input logic [3:0] ra, input int k,
                         input logic [31:0] rdata);
        exp_t r;
        bit   mem, ab;
        int   ncyc;
        mem   = ld | st;
        ab    = mem && (k >= TIMEOUT);
        ncyc  = !mem ? 1 : (ab ? TIMEOUT : k + 1);
        err_m = err_m | ab;
        r.pc = pc; r.alu = alu; r.ins = ins; r.rd = rd; r.ra = ra;
        r.ld   = (ld && !ab) ? rdata : 32'h0;
        r.wb   = ab ? 1'b0 : wb;
        r.isld = ab ? 1'b0 : ld;
        r.call = ab ? 1'b0 : call;
        r.ab = ab; r.err = err_m; r.we = st;
        r.addr = alu; r.wdata = rd2;
        r.stalls = ncyc - 1;
        r.reqs   = mem ? ncyc : 0;
        sb.push_back(r);
        pc_M = pc; alu_result_M = alu; rd2_M = rd2; instruction_M = ins;
        isLd_M = ld; isSt_M = st; isWb_M = wb; isCall_M = call;
        RD_M = rd; ra_M = ra;
        em_valid = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            dmem_ack   = mem ? (c == k) : 1'($urandom_range(1));
            dmem_rdata = (mem && c == k) ? rdata : $urandom;
            @(posedge clk); #1;
        end
    endtask

    // Monitor: counts request/stall cycles, checks bubbles and commits.
    initial begin
        int   n_req, n_stall;
        exp_t r;
        n_req = 0;
        n_stall = 0;
        forever begin
            @(negedge clk);
            if (em_valid && !rst) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    r = sb[0];
                    chk("fwd", data_M_E, r.alu);
                    if (dmem_req) begin
                        n_req++;
                        chk("dmem_we", dmem_we, r.we);
                        chk("dmem_addr", dmem_addr, r.addr);
                        chk("dmem_wdata", dmem_wdata, r.wdata);
                    end
                    if (stall_M) begin
                        n_stall++;
                        @(posedge clk); #2;
                        chk("bubble_flags", {isWb_W, isLd_W, isCall_W}, 0);
                        chk("bubble_ins", instruction_W, 0);
                    end else begin
                        @(posedge clk); #2;
                        void'(sb.pop_front());
                        chk("stall_cycles", n_stall, r.stalls);
                        chk("req_cycles", n_req, r.reqs);
                        chk("pc_W", pc_W, r.pc);
                        if (!r.ab) chk("alu_W", alu_result_W, r.alu);
                        chk("ld_W", ld_result_W, r.ld);
                        chk("ins_W", instruction_W, r.ins);
                        chk("flags_W", {isWb_W, isLd_W, isCall_W},
                            {r.wb, r.isld, r.call});
                        chk("idx_W", {RD_W, ra_W}, {r.rd, r.ra});
                        chk("mem_err", mem_err, r.err);
                        n_req = 0;
                        n_stall = 0;
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, k, r;
        rst = 1'b1;
        pc_M = 0; alu_result_M = 32'h40; rd2_M = 0; instruction_M = 0;
        isLd_M = 1'b1; isSt_M = 1'b0; isWb_M = 1'b1; isCall_M = 1'b0;
        RD_M = 0; ra_M = 0; dmem_ack = 1'b0; dmem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall_M, 0);
        chk("rst_mw", pc_W | alu_result_W | ld_result_W | instruction_W, 0);
        chk("rst_ctl", {isWb_W, isLd_W, isCall_W, RD_W, ra_W, mem_err}, 0);
        rst = 1'b0;

        issue(0, 0, 1, 0, 32'h100, 32'h7, 32'h0, 32'h00000013,
              4'd3, 4'd15, 0, 0);
        issue(1, 0, 1, 0, 32'h104, 32'h40, 32'h0, 32'h00000023,
              4'd4, 4'd15, 0, 32'h12345678);
        issue(0, 1, 0, 0, 32'h108, 32'h80, 32'hCAFEF00D, 32'h00000033,
              4'd0, 4'd15, 3, 0);
        issue(1, 0, 1, 0, 32'h10C, 32'h44, 32'h0, 32'h00000043,
              4'd5, 4'd15, TIMEOUT - 1, 32'h1);
        issue(1, 0, 1, 0, 32'h110, 32'h48, 32'h0, 32'h00000053,
              4'd6, 4'd15, TIMEOUT, 32'h5);
        issue(0, 0, 1, 0, 32'h114, 32'h9, 32'h0, 32'h00000063,
              4'd7, 4'd15, 0, 0);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(2);
            r = $urandom_range(7);
            k = (r < 2) ? 0 : (r == 2) ? TIMEOUT - 1 :
                (r == 3) ? TIMEOUT : $urandom_range(TIMEOUT - 1);
            issue(kind == 1, kind == 2, 1'($urandom_range(1)),
                  1'($urandom_range(1)), $urandom, $urandom, $urandom,
                  $urandom, 4'($urandom), 4'($urandom), k, $urandom);
        end

        em_valid = 1'b0;
        isLd_M = 1'b0; isSt_M = 1'b0; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);

        // reset in the second wait cycle, ack arrives during/after reset
        isLd_M = 1'b1; alu_result_M = 32'h200; isWb_M = 1'b1;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wait_stall", stall_M, 1);
        rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("rstw_req", dmem_req, 0);
        chk("rstw_stall", stall_M, 0);
        @(posedge clk); #1;
        chk("rstw_mw", pc_W | alu_result_W | ld_result_W | instruction_W, 0);
        chk("rstw_ctl", {isWb_W, isLd_W, isCall_W, RD_W, ra_W, mem_err}, 0);
        rst = 1'b0; isLd_M = 1'b0; isWb_M = 1'b0;
        #1;
        chk("late_ack_req", dmem_req, 0);
        @(posedge clk); #1;
        chk("late_ack_ld", ld_result_W, 0);
        chk("late_ack_err", mem_err, 0);
        chk("late_ack_isld", isLd_W, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
